// File: rtl/vga_stream_rx.sv
// ---------------------------------------------------------------------------
// vga_stream_rx
//
// Receive end of a VGA output. Registers the incoming colour/meta/sync
// signals, locks a local raster counter to the falling edges of the
// active-low syncs, and emits every visible pixel as a valid/ready stream
// through a small first-word-fall-through FIFO.
//
// Ports
//   clk, reset_n          pixel clock (rising edge), async active-low reset
//   enable                capture enable; low forces SEEK, FIFO keeps draining
//   clear_err             one-cycle pulse clearing err_h, err_v, overflow
//   vga_red/grn/blu/meta  incoming pixel colour components and side-band meta
//   vga_hsync, vga_vsync  incoming active-low syncs
//   out_x, out_y          raster coordinate of the emitted pixel
//   out_color, out_meta   {red,grn,blu} and meta of the emitted pixel
//   out_sof, out_eol      pixel is (0,0) / last pixel of its line
//   out_valid, out_ready  stream handshake
//   locked                timing lock currently held
//   err_h, err_v          sticky sync-position errors
//   overflow              sticky: a visible pixel was dropped on a full FIFO
// ---------------------------------------------------------------------------
module vga_stream_rx #(
  parameter int H_VISIBLE     = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_PULSE  = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int H_WHOLE_LINE  = 800,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_PULSE  = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter int V_WHOLE_FRAME = 525,
  parameter int PIXEL_BITS    = 12,
  parameter int META_BITS     = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          clear_err,
  input  logic [PIXEL_BITS/3-1:0]       vga_red,
  input  logic [PIXEL_BITS/3-1:0]       vga_grn,
  input  logic [PIXEL_BITS/3-1:0]       vga_blu,
  input  logic [META_BITS-1:0]          vga_meta,
  input  logic                          vga_hsync,
  input  logic                          vga_vsync,
  output logic [$clog2(H_VISIBLE)-1:0]  out_x,
  output logic [$clog2(V_VISIBLE)-1:0]  out_y,
  output logic [PIXEL_BITS-1:0]         out_color,
  output logic [META_BITS-1:0]          out_meta,
  output logic                          out_sof,
  output logic                          out_eol,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          locked,
  output logic                          err_h,
  output logic                          err_v,
  output logic                          overflow
);

  localparam int COLOR_BITS = PIXEL_BITS / 3;
  localparam int XW  = $clog2(H_VISIBLE);
  localparam int YW  = $clog2(V_VISIBLE);
  localparam int XCW = $clog2(H_WHOLE_LINE);
  localparam int YCW = $clog2(V_WHOLE_FRAME);
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [XCW-1:0] H_SYNC_START = XCW'(H_VISIBLE + H_FRONT_PORCH);
  localparam logic [XCW-1:0] H_LAST       = XCW'(H_WHOLE_LINE - 1);
  localparam logic [XCW-1:0] H_VIS_C      = XCW'(H_VISIBLE);
  localparam logic [XCW-1:0] H_EOL        = XCW'(H_VISIBLE - 1);
  localparam logic [YCW-1:0] V_SYNC_START = YCW'(V_VISIBLE + V_FRONT_PORCH);
  localparam logic [YCW-1:0] V_LAST       = YCW'(V_WHOLE_FRAME - 1);
  localparam logic [YCW-1:0] V_VIS_C      = YCW'(V_VISIBLE);
  localparam logic [AW:0]    DEPTH_C      = (AW + 1)'(FIFO_DEPTH);

  // The wrap points come from the WHOLE parameters, so they must agree with
  // the individual porch/pulse widths or lock would never hold.
  if (H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH != H_WHOLE_LINE) begin : g_bad_h
    $error("vga_stream_rx: horizontal timing parameters are inconsistent");
  end
  if (V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH != V_WHOLE_FRAME) begin : g_bad_v
    $error("vga_stream_rx: vertical timing parameters are inconsistent");
  end
  if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_fifo
    $error("vga_stream_rx: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic {SEEK, LOCKED} state_t;

  typedef struct packed {
    logic [XW-1:0]           x;
    logic [YW-1:0]           y;
    logic [3*COLOR_BITS-1:0] color;
    logic [META_BITS-1:0]    meta;
    logic                    sof;
    logic                    eol;
  } entry_t;

  state_t                  state_q, state_d;
  logic [COLOR_BITS-1:0]   s1_red_q, s1_grn_q, s1_blu_q;
  logic [META_BITS-1:0]    s1_meta_q;
  logic                    s1_hs_q, s1_vs_q, prev_hs_q, prev_vs_q;
  logic [XCW-1:0]          x_q, x_d;
  logic [YCW-1:0]          y_q, y_d;
  logic                    err_h_q, err_h_d, err_v_q, err_v_d, ovf_q, ovf_d;
  entry_t                  mem_q [FIFO_DEPTH];
  entry_t                  mem_d [FIFO_DEPTH];
  logic [AW:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic   hfall, vfall, bad_h, bad_v, active, visible;
  logic   push, pop, fifo_empty, fifo_full;
  entry_t new_entry, head;

  // Next-state logic: sync-edge checking against the local raster counter,
  // counter advance, FIFO push/pop and the sticky status flags.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    hfall = prev_hs_q & ~s1_hs_q;
    vfall = prev_vs_q & ~s1_vs_q;

    // A fall at the wrong place and a missing fall at the right place are
    // both just "fall present != fall expected".
    bad_h = hfall ^ (x_q == H_SYNC_START);
    bad_v = vfall ^ ((x_q == '0) && (y_q == V_SYNC_START));

    active  = (state_q == LOCKED) && enable;
    visible = (x_q < H_VIS_C) && (y_q < V_VIS_C);
    push    = active && !bad_h && !bad_v && visible;

    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = ((wr_ptr_q - rd_ptr_q) == DEPTH_C);
    pop        = !fifo_empty && out_ready;

    new_entry.x     = x_q[XW-1:0];
    new_entry.y     = y_q[YW-1:0];
    new_entry.color = {s1_red_q, s1_grn_q, s1_blu_q};
    new_entry.meta  = s1_meta_q;
    new_entry.sof   = (x_q == '0) && (y_q == '0);
    new_entry.eol   = (x_q == H_EOL);

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    if (push && (!fifo_full || pop)) begin
      mem_d[wr_ptr_q[AW-1:0]] = new_entry;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    err_h_d = (active && bad_h) || (err_h_q && !clear_err);
    err_v_d = (active && bad_v) || (err_v_q && !clear_err);
    ovf_d   = (push && fifo_full && !pop) || (ovf_q && !clear_err);

    unique case (state_q)
      SEEK: begin
        // The vsync fall marks (0, V_SYNC_START); the next s1 sample is x=1.
        if (enable && vfall) begin
          state_d = LOCKED;
          x_d     = XCW'(1);
          y_d     = V_SYNC_START;
        end
      end
      LOCKED: begin
        if (!enable || bad_h || bad_v) begin
          state_d = SEEK;
        end else if (x_q == H_LAST) begin
          x_d = '0;
          y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      default: state_d = SEEK;
    endcase
  end

  // All state, including the input stage, resets asynchronously; the sync
  // history resets high so an idle (high) sync never looks like a fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= SEEK;
      s1_red_q  <= '0;
      s1_grn_q  <= '0;
      s1_blu_q  <= '0;
      s1_meta_q <= '0;
      s1_hs_q   <= 1'b1;
      s1_vs_q   <= 1'b1;
      prev_hs_q <= 1'b1;
      prev_vs_q <= 1'b1;
      x_q       <= '0;
      y_q       <= '0;
      err_h_q   <= 1'b0;
      err_v_q   <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      s1_red_q  <= vga_red;
      s1_grn_q  <= vga_grn;
      s1_blu_q  <= vga_blu;
      s1_meta_q <= vga_meta;
      s1_hs_q   <= vga_hsync;
      s1_vs_q   <= vga_vsync;
      prev_hs_q <= s1_hs_q;
      prev_vs_q <= s1_vs_q;
      x_q       <= x_d;
      y_q       <= y_d;
      err_h_q   <= err_h_d;
      err_v_q   <= err_v_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_q     <= mem_d;
    end
  end

  // Fields are forced to zero while empty so nothing stale is presented.
  assign head      = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign out_valid = !fifo_empty;
  assign out_x     = head.x;
  assign out_y     = head.y;
  assign out_color = PIXEL_BITS'(head.color);
  assign out_meta  = head.meta;
  assign out_sof   = head.sof;
  assign out_eol   = head.eol;
  assign locked    = (state_q == LOCKED);
  assign err_h     = err_h_q;
  assign err_v     = err_v_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_vga_stream_rx.sv
// ---------------------------------------------------------------------------
// tb_vga_stream_rx
//
// Drives vga_stream_rx (reduced 23x16 raster, 16x8 visible) from an ideal
// VGA source that knows the true raster position of every sample it emits,
// with optional late-hsync faults, enable drops, stalls and a mid-frame
// reset. A reference model expressed in raster positions and a queue of
// expected pixels predicts every output.
// ---------------------------------------------------------------------------
module tb_vga_stream_rx;

  localparam int HV = 16, HFP = 2, HSP = 3, HBP = 2, HW = 23;
  localparam int VV = 8,  VFP = 2, VSP = 3, VBP = 3, VW = 16;
  localparam int HSS = HV + HFP;
  localparam int VSS = VV + VFP;
  localparam int FR  = HW * VW;
  localparam int DEPTH = 4;

  logic        clk, reset_n, enable, clear_err;
  logic [3:0]  vga_red, vga_grn, vga_blu, vga_meta;
  logic        vga_hsync, vga_vsync;
  logic [3:0]  out_x;
  logic [2:0]  out_y;
  logic [11:0] out_color;
  logic [3:0]  out_meta;
  logic        out_sof, out_eol, out_valid, out_ready;
  logic        locked, err_h, err_v, overflow;

  vga_stream_rx #(
    .H_VISIBLE(HV), .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HSP), .H_BACK_PORCH(HBP), .H_WHOLE_LINE(HW),
    .V_VISIBLE(VV), .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VSP), .V_BACK_PORCH(VBP), .V_WHOLE_FRAME(VW),
    .PIXEL_BITS(12), .META_BITS(4), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear_err(clear_err),
    .vga_red(vga_red), .vga_grn(vga_grn), .vga_blu(vga_blu), .vga_meta(vga_meta),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .out_x(out_x), .out_y(out_y), .out_color(out_color), .out_meta(out_meta),
    .out_sof(out_sof), .out_eol(out_eol), .out_valid(out_valid), .out_ready(out_ready),
    .locked(locked), .err_h(err_h), .err_v(err_v), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  x;
    logic [2:0]  y;
    logic [11:0] color;
    logic [3:0]  meta;
    logic        sof;
    logic        eol;
  } pix_t;

  // Reference model state: expected output queue, lock and sticky flags,
  // plus the sample the receiver currently holds and the one before it.
  pix_t        expQ[$];
  bit          mLocked, mErrH, mErrV, mOvf;
  bit          heldHs, heldVs, prevHs, prevVs;
  int          heldX, heldY;
  logic [11:0] heldColor;
  logic [3:0]  heldMeta;

  int sx, sy, cyc;
  int vectors, miscompares;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at sample (%0d,%0d): got %0h, expected %0h", tag, sx, sy, obs, exp);
    end
  endtask

  task automatic checkAll();
    pix_t got;
    got = '{x: out_x, y: out_y, color: out_color, meta: out_meta, sof: out_sof, eol: out_eol};
    checkOutput("out_valid", 64'(out_valid), 64'(expQ.size() != 0));
    if (expQ.size() != 0) checkOutput("pixel", 64'(got), 64'(expQ[0]));
    checkOutput("locked", 64'(locked), 64'(mLocked));
    checkOutput("err_h", 64'(err_h), 64'(mErrH));
    checkOutput("err_v", 64'(err_v), 64'(mErrV));
    checkOutput("overflow", 64'(overflow), 64'(mOvf));
  endtask

  task automatic checkResetState();
    pix_t got;
    got = '{x: out_x, y: out_y, color: out_color, meta: out_meta, sof: out_sof, eol: out_eol};
    checkOutput("reset_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_fields", 64'(got), 64'd0);
    checkOutput("reset_locked", 64'(locked), 64'd0);
    checkOutput("reset_flags", 64'({err_h, err_v, overflow}), 64'd0);
  endtask

  task automatic modelReset();
    expQ.delete();
    mLocked = 0; mErrH = 0; mErrV = 0; mOvf = 0;
    heldHs = 1; heldVs = 1; prevHs = 1; prevVs = 1;
    heldX = -1; heldY = -1; heldColor = '0; heldMeta = '0;
  endtask

  // One clock of receiver behaviour in terms of true raster positions: the
  // held sample is judged against where the syncs must fall.
  task automatic modelStep(input bit en, input bit clr, input bit rdy);
    bit pop, wasFull, hf, vf, expH, expV, setH, setV, setO;
    setH = 0; setV = 0; setO = 0;
    wasFull = (expQ.size() == DEPTH);
    pop = (expQ.size() != 0) && rdy;
    hf = prevHs && !heldHs;
    vf = prevVs && !heldVs;
    if (pop) void'(expQ.pop_front());
    if (mLocked) begin
      if (!en) begin
        mLocked = 0;
      end else begin
        expH = (heldX == HSS);
        expV = (heldX == 0) && (heldY == VSS);
        if (hf != expH || vf != expV) begin
          setH = (hf != expH);
          setV = (vf != expV);
          mLocked = 0;
        end else if (heldX < HV && heldY < VV) begin
          if (wasFull && !pop) setO = 1;
          else expQ.push_back('{x: 4'(heldX), y: 3'(heldY), color: heldColor, meta: heldMeta,
                                sof: (heldX == 0 && heldY == 0), eol: (heldX == HV - 1)});
        end
      end
    end else if (en && vf) begin
      mLocked = 1;
    end
    mErrH = setH || (mErrH && !clr);
    mErrV = setV || (mErrV && !clr);
    mOvf  = setO || (mOvf && !clr);
  endtask

  // Drives one source sample plus controls, advances the model, waits one
  // clock and compares every output.
  task automatic applyStimulus(input bit en, input bit clr, input bit rdy, input int faultLine);
    int   off;
    bit   hs, vs;
    logic [11:0] col;
    logic [3:0]  meta;
    off  = (sy == faultLine) ? 1 : 0;
    hs   = !(sx >= HSS + off && sx < HSS + off + HSP);
    vs   = !(sy >= VSS && sy < VSS + VSP);
    col  = 12'($urandom);
    meta = 4'($urandom);
    enable = en; clear_err = clr; out_ready = rdy;
    vga_red = col[11:8]; vga_grn = col[7:4]; vga_blu = col[3:0];
    vga_meta = meta; vga_hsync = hs; vga_vsync = vs;
    modelStep(en, clr, rdy);
    prevHs = heldHs; prevVs = heldVs;
    heldHs = hs; heldVs = vs; heldX = sx; heldY = sy;
    heldColor = col; heldMeta = meta;
    if (sx == HW - 1) begin
      sx = 0;
      sy = (sy == VW - 1) ? 0 : sy + 1;
    end else begin
      sx++;
    end
    cyc++;
    @(negedge clk);
    checkAll();
  endtask

  function automatic bit readyFor(input int mode);
    case (mode)
      1:       return !(sy == 2);
      2:       return cyc[0];
      3:       return ($urandom_range(0, 3) != 0);
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit clearFor(input int mode);
    case (mode)
      1:       return (sy == 5 && sx == 0);
      3:       return ($urandom_range(0, 63) == 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic runCycles(input int n, input int mode, input int faultLine, input bit en);
    for (int i = 0; i < n; i++) applyStimulus(en, clearFor(mode), readyFor(mode), faultLine);
  endtask

  task automatic runTo(input int ty, input int tx, input int mode);
    for (int i = 0; i < FR && !(sy == ty && sx == tx); i++) applyStimulus(1'b1, clearFor(mode), readyFor(mode), -1);
  endtask

  // Reset pulse spanning one rising edge; outputs must drop immediately.
  task automatic pulseReset();
    reset_n = 1'b0;
    #1;
    modelReset();
    checkResetState();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    clk = 0; reset_n = 1; enable = 0; clear_err = 0; out_ready = 0;
    vga_red = '0; vga_grn = '0; vga_blu = '0; vga_meta = '0;
    vga_hsync = 1; vga_vsync = 1;
    sx = 0; sy = 0; cyc = 0; vectors = 0; miscompares = 0;
    modelReset();
    #2 reset_n = 0;
    #2 checkResetState();
    @(negedge clk);
    reset_n = 1;

    runCycles(3 * FR, 0, -1, 1'b1);
    runCycles(FR, 0, 3, 1'b1);
    runCycles(2 * FR, 0, -1, 1'b1);
    runCycles(2 * FR, 1, -1, 1'b1);
    runCycles(2 * FR, 2, -1, 1'b1);
    runTo(5, 8, 0);
    runCycles(40, 2, -1, 1'b0);
    runCycles(2 * FR, 3, -1, 1'b1);
    runTo(4, 7, 3);
    pulseReset();
    runCycles(2 * FR, 3, -1, 1'b1);
    runCycles(FR, 0, -1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
